// File: rtl/fifo_burst_reader.sv
// ============================================================================
// fifo_burst_reader: drains burst_len words from a show-ahead FIFO onto a
// valid/ready stream through a 2-entry skid buffer. Rev 1.0
// ============================================================================
`default_nettype none

module fifo_burst_reader #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [CW-1:0] burst_len,
  output logic          busy,
  output logic          done,
  output logic          fifo_rd_en,
  input  logic [W-1:0]  fifo_rd_data,
  input  logic          fifo_empty,
  output logic          m_valid,
  output logic [W-1:0]  m_data,
  output logic          m_last,
  input  logic          m_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [1:0]    occ_q, occ_d;
  logic          done_q, done_d;
  logic [W-1:0]  data0_q, data0_d, data1_q, data1_d;
  logic          last0_q, last0_d, last1_q, last1_d;

  logic          w_pop;
  logic          w_hs;
  logic          w_pop_last;

  // Pop decision uses only registered state, so m_ready never reaches fifo_rd_en.
  assign w_pop      = (state_q == ST_RUN) && (rem_q != '0) && !fifo_empty && (occ_q != 2'd2);
  assign w_hs       = (occ_q != 2'd0) && m_ready;
  assign w_pop_last = (rem_q == CW'(1));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    occ_d   = occ_q;
    done_d  = 1'b0;
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;

    case ({w_pop, w_hs})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          data0_d = fifo_rd_data;
          last0_d = w_pop_last;
        end else begin
          data1_d = fifo_rd_data;
          last1_d = w_pop_last;
        end
      end
      2'b01: begin
        occ_d   = occ_q - 2'd1;
        data0_d = data1_q;
        last0_d = last1_q;
      end
      2'b11: begin
        // Head leaves while a new word arrives; occupancy is unchanged.
        if (occ_q == 2'd1) begin
          data0_d = fifo_rd_data;
          last0_d = w_pop_last;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = fifo_rd_data;
          last1_d = w_pop_last;
        end
      end
      default: ;
    endcase

    if (w_pop) begin
      rem_d = rem_q - CW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d = burst_len;
          if (burst_len != '0) begin
            state_d = ST_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (w_pop && w_pop_last) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (occ_d == 2'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      occ_q   <= 2'd0;
      done_q  <= 1'b0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      occ_q   <= occ_d;
      done_q  <= done_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
    end
  end

  // Payload needs no reset; it is only observed behind m_valid.
  always_ff @(posedge clk) begin
    data0_q <= data0_d;
    data1_q <= data1_d;
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign fifo_rd_en = w_pop;
  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = data0_q;
  assign m_last     = last0_q && (occ_q != 2'd0);

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ============================================================================
// tb_fifo_burst_reader: FIFO model, scoreboard and vector table for the
// burst reader. Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_burst_reader;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [CW-1:0] burst_len;
  logic          busy;
  logic          done;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_rd_data;
  logic          fifo_empty;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          m_ready;

  always #5 clk = ~clk;

  fifo_burst_reader #(.W(W), .CW(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .burst_len    (burst_len),
    .busy         (busy),
    .done         (done),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_last       (m_last),
    .m_ready      (m_ready)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  typedef struct {
    int len;
    int preload;
    int mode;        // 0: m_ready high, 1: m_ready 1,0,0 repeating
    int exp_cycles;  // edges from start acceptance to done; -1 skips
    int exp_hs;
    int exp_left;
  } vec_t;

  exp_t         exp_q[$];
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] src_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           pop_cnt = 0;
  int           hs_cnt  = 0;
  logic         done_exp = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;
  logic [W-1:0] next_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic dn;
    exp_t e;
    if (!reset_n) begin
      done_exp   = 1'b0;
      prev_stall = 1'b0;
      return;
    end
    if (done || done_exp) begin
      check("done_pulse", done, done_exp);
      if (done) check("busy_in_done", busy, 1'b0);
    end
    dn = 1'b0;
    if (start && !busy && burst_len == '0) dn = 1'b1;
    if (prev_stall) begin
      check("stall_valid", m_valid, 1'b1);
      check("stall_data", m_data, prev_data);
      check("stall_last", m_last, prev_last);
    end
    if (m_valid && m_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_word: got data %0h, expected no word", m_data);
      end else begin
        e = exp_q.pop_front();
        check("m_data", m_data, e.data);
        check("m_last", m_last, e.last);
        if (e.last) dn = 1'b1;
      end
    end
    if (fifo_rd_en) check("underflow_guard", fifo_empty, 1'b0);
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    done_exp   = dn;
  endtask

  // One clock: observe at the falling edge, then update the FIFO model just after the rising edge.
  task automatic tick();
    logic rd;
    @(negedge clk);
    monitor();
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_word(input logic [W-1:0] v);
    fifo_q.push_back(v);
    src_q.push_back(v);
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      push_word(next_val);
      next_val = next_val + 8'd1;
    end
  endtask

  task automatic expect_burst(input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.data = (src_q.size() > 0) ? src_q.pop_front() : '0;
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int mode, output int cycles);
    cycles = 0;
    while (!done && cycles < 300) begin
      m_ready = (mode == 0) ? 1'b1 : ((cycles % 3) == 0);
      tick();
      cycles++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected a done pulse", cycles);
    end
  endtask

  task automatic launch(input int len);
    burst_len = CW'(len);
    start     = 1'b1;
    expect_burst(len);
    tick();
    start     = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int cycles;
    int p0;
    int h0;

    vecs[0] = '{len: 8, preload: 8, mode: 0, exp_cycles: 9,  exp_hs: 8, exp_left: 0};
    vecs[1] = '{len: 0, preload: 0, mode: 0, exp_cycles: 0,  exp_hs: 0, exp_left: 0};
    vecs[2] = '{len: 1, preload: 1, mode: 0, exp_cycles: 2,  exp_hs: 1, exp_left: 0};
    vecs[3] = '{len: 6, preload: 6, mode: 1, exp_cycles: -1, exp_hs: 6, exp_left: 0};
    vecs[4] = '{len: 3, preload: 5, mode: 0, exp_cycles: 4,  exp_hs: 3, exp_left: 2};
    vecs[5] = '{len: 2, preload: 0, mode: 0, exp_cycles: 3,  exp_hs: 2, exp_left: 0};

    reset_n      = 1'b0;
    start        = 1'b0;
    burst_len    = '0;
    m_ready      = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    next_val     = 8'h01;

    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_rd_en", fifo_rd_en, 1'b0);

    foreach (vecs[i]) begin
      preload(vecs[i].preload);
      p0 = pop_cnt;
      h0 = hs_cnt;
      m_ready = 1'b1;
      launch(vecs[i].len);
      wait_done(vecs[i].mode, cycles);
      if (vecs[i].exp_cycles >= 0) check($sformatf("vec%0d_cycles", i), cycles, vecs[i].exp_cycles);
      check($sformatf("vec%0d_pops", i), pop_cnt - p0, vecs[i].exp_hs);
      m_ready = 1'b1;
      tick();
      check($sformatf("vec%0d_handshakes", i), hs_cnt - h0, vecs[i].exp_hs);
      check($sformatf("vec%0d_fifo_left", i), fifo_q.size(), vecs[i].exp_left);
    end

    // Backpressure: a full stall lets exactly two words into the skid buffer.
    preload(6);
    p0 = pop_cnt;
    h0 = hs_cnt;
    m_ready = 1'b0;
    launch(6);
    repeat (8) tick();
    check("bp_stalled_pops", pop_cnt - p0, 2);
    check("bp_valid", m_valid, 1'b1);
    check("bp_rd_en", fifo_rd_en, 1'b0);
    wait_done(1, cycles);
    m_ready = 1'b1;
    tick();
    check("bp_handshakes", hs_cnt - h0, 6);

    // Starvation: two words now, three more four cycles later.
    push_word(8'h40);
    push_word(8'h41);
    src_q.push_back(8'h42);
    src_q.push_back(8'h43);
    src_q.push_back(8'h44);
    p0 = pop_cnt;
    h0 = hs_cnt;
    m_ready = 1'b1;
    launch(5);
    repeat (4) tick();
    check("starve_busy", busy, 1'b1);
    check("starve_rd_en", fifo_rd_en, 1'b0);
    fifo_q.push_back(8'h42);
    fifo_q.push_back(8'h43);
    fifo_q.push_back(8'h44);
    wait_done(0, cycles);
    tick();
    check("starve_pops", pop_cnt - p0, 5);
    check("starve_handshakes", hs_cnt - h0, 5);

    // A start pulse while running must not reload the remaining count.
    preload(6);
    p0 = pop_cnt;
    h0 = hs_cnt;
    m_ready = 1'b0;
    launch(6);
    repeat (2) tick();
    burst_len = CW'(2);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    wait_done(0, cycles);
    tick();
    check("restart_pops", pop_cnt - p0, 6);
    check("restart_handshakes", hs_cnt - h0, 6);

    // Back-to-back: second start lands in the done cycle of the first burst.
    preload(7);
    h0 = hs_cnt;
    m_ready = 1'b1;
    launch(4);
    wait_done(0, cycles);
    launch(3);
    wait_done(0, cycles);
    tick();
    check("b2b_handshakes", hs_cnt - h0, 7);
    check("b2b_fifo_left", fifo_q.size(), 0);

    // Reset in the middle of a 10-word burst after four pops.
    preload(10);
    p0 = pop_cnt;
    m_ready = 1'b1;
    launch(10);
    for (int k = 0; k < 20 && (pop_cnt - p0) < 4; k++) tick();
    check("mid_rst_pops_seen", pop_cnt - p0, 4);
    reset_n = 1'b0;
    tick();
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_rd_en", fifo_rd_en, 1'b0);
    exp_q.delete();
    fifo_q.delete();
    src_q.delete();
    reset_n = 1'b1;
    repeat (8) tick();
    check("mid_rst_no_done", done, 1'b0);
    check("mid_rst_idle", busy, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
